conv_job_sequencer: RTL and testbench
=====================================

// Module: conv_job_sequencer
// PURPOSE
//  Job-level controller for the shared-weight convolution PE grid. Accepts one
//  image+filter job over a valid/ready handshake and latches it. Clears the PE
//  accumulators, then steps the filter tap index through M*M taps, driving the
//  current weight and tap coordinates to the array. Captures the finished sums
//  and presents them downstream under valid/ready. Sits between the job source
//  (DMA/host regs) and the PE grid; it replaces the grid's free-running tap counter.
// PARAMETERS
//  N          3  image side (N x N)
//  M          2  filter side (M x M); 2 <= M <= N
//  data_width 1  element width of image and filter
//  PIPE_LAT   1  cycles from last enabled tap until pe_sum is final (>=1)
// PORTS
//  clk        in   1                       clock, rising edge
//  reset      in   1                       async, active-high
//  in_valid   in   1                       job offered
//  in_ready   out  1                       job accepted when in_valid&in_ready
//  in_a       in   [data_width-1:0] x NxN  image
//  in_b       in   [data_width-1:0] x MxM  filter
//  abort      in   1                       sync kill of the in-flight job
//  pe_clear   out  1                       sync clear of all PE accumulators
//  pe_en      out  1                       PE accumulate enable for this tap
//  tap_row    out  $clog2(M)               current tap row m
//  tap_col    out  $clog2(M)               current tap col n
//  b_tap      out  [data_width-1:0]        in_b_reg[tap_row][tap_col]
//  img        out  [data_width-1:0] x NxN  latched image (stable for the whole job)
//  pe_sum     in   [2*data_width:0] x OSxOS  grid sums, OS=N-M+1
//  out_valid  out  1                       result available
//  out_ready  in   1                       result consumed when out_valid&out_ready
//  out_p      out  [2*data_width:0] x OSxOS  captured result
//  busy       out  1                       state != IDLE
//  job_count  out  16                      completed handshakes, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0 except in_ready=1. img, latched B, and out_p are 0.
//  FSM states: IDLE -> CLEAR -> RUN -> DRAIN -> OUT.
//   IDLE:  in_ready=1. On accept: latch in_a/in_b, go to CLEAR.
//   CLEAR: 1 cycle. pe_clear=1, pe_en=0.
//   RUN:   M*M cycles. pe_en=1, tap k=0..M*M-1, tap_row=k/M, tap_col=k%M.
//          Row-major order; k advances 1 per cycle and never wraps within a job.
//   DRAIN: PIPE_LAT cycles. pe_en=0. On the last DRAIN cycle, out_p<=pe_sum.
//   OUT:   out_valid=1, out_p held until out_ready.
//          in_ready=out_ready in OUT, so a new job accepted in the same cycle as
//          the handshake goes straight to CLEAR (back-to-back, no IDLE bubble).
//          Handshake without a new job -> IDLE.
//  Latency: accept edge to out_valid rising = 1 + M*M + PIPE_LAT cycles.
//   For defaults this is 6.
//  in_ready=0 in CLEAR/RUN/DRAIN. Input ports are ignored then; the latched job is
//   never disturbed.
//  abort in CLEAR/RUN/DRAIN: next state IDLE.
//   No out_valid, no out_p update, no job_count increment. pe_en drops next cycle.
//   abort in IDLE or OUT has no effect. In OUT the pending result is preserved.
//  job_count increments on each out_valid&out_ready.
//  Arithmetic: the controller performs none. Width of pe_sum/out_p is 2*data_width+1,
//   unchanged from the grid.
//  Async reset mid-job: immediate return to reset values. The partial job is lost.
//  b_tap is combinational from the latched B and the tap counter. All other outputs are registered.
// STRUCTURE
//  conv_pkg: state_t enum {IDLE,CLEAR,RUN,DRAIN,OUT}, plus these functions of N, M:
//   OUT_SIZE=N-M+1, TAPS=M*M, TAP_W=$clog2(TAPS), RC_W=$clog2(M).
//  Sub-module conv_tap_counter holds the tap counter and the DRAIN counter.
//   Inputs: start, en. Outputs: tap_row, tap_col, last_tap, drain_done.
//  The top level holds the FSM, the job latches, out_p capture and job_count.
// TESTING (bench holds a behavioural MAC grid with PIPE_LAT=1; N=3,M=2,data_width=4)
//  1. Basic job: A=1..9 row-major, B=[[1,0],[0,1]]
//     -> out_valid 6 cycles after accept; out_p=[[6,8],[12,14]].
//     Taps seen in order (0,0),(0,1),(1,0),(1,1).
//  2. Back-to-back: hold in_valid with a second job (B=[[1,1],[1,1]]) while
//     out_ready=1 -> second accept on the OUT handshake cycle.
//     Second out_p=[[12,16],[24,28]]; job_count=2.
//  3. Backpressure: out_ready=0 for 10 cycles -> out_valid and out_p stable;
//     in_ready=0; no extra pe_en pulses.
//  4. Abort during RUN tap 2 -> IDLE next cycle; no out_valid; job_count unchanged.
//     The next job's result is correct, proving the clear works.
//  5. Async reset asserted mid-DRAIN -> all outputs at reset values without a clock edge.
//     Recovery job correct.
//  6. job_count preloaded via force to 0xFFFF, then one job -> job_count=0.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Package : conv_pkg
// Purpose : Shared types and size helpers for the convolution job sequencer.
//           Holds the sequencer state encoding and the derived sizes that
//           depend on the image side N and the filter side M.
// Revision: 1.0 - initial release
// ============================================================================
package conv_pkg;

  // Job sequencer states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_t;

  // Side of the valid-convolution result grid
  function automatic int out_size(input int n, input int m);
    return n - m + 1;
  endfunction

  // Number of filter taps visited per job
  function automatic int taps(input int m);
    return m * m;
  endfunction

  // Width of a flat tap index
  function automatic int tap_w(input int m);
    return $clog2(m * m);
  endfunction

  // Width of a tap row or column coordinate
  function automatic int rc_w(input int m);
    return $clog2(m);
  endfunction

endpackage : conv_pkg
`default_nettype wire

// File: rtl/conv_tap_counter.sv
`default_nettype none
// ============================================================================
// Module  : conv_tap_counter
// Purpose : Walks the filter taps in row-major order, then counts out the
//           PE pipeline drain. Stops at the last tap (no wrap within a job)
//           and holds once the drain count is complete.
// Ports   : clk, reset      - clock, async active-high reset
//           start           - restart at tap (0,0) with the drain count cleared
//           en              - advance the tap walk, then the drain count
//           tap_row/tap_col - current tap coordinate (registered)
//           last_tap        - current tap is the final one of the walk
//           drain_done      - current cycle is the final drain cycle
// Revision: 1.0 - initial release
// ============================================================================
module conv_tap_counter
  import conv_pkg::*;
#(
  parameter int M        = 2,
  parameter int PIPE_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                en,
  output logic [rc_w(M)-1:0]  tap_row,
  output logic [rc_w(M)-1:0]  tap_col,
  output logic                last_tap,
  output logic                drain_done
);

  localparam int RC_W = rc_w(M);
  localparam int DR_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [RC_W-1:0] c_last_rc    = RC_W'(M - 1);
  localparam logic [DR_W-1:0] c_last_drain = DR_W'(PIPE_LAT - 1);

  logic [RC_W-1:0] r_row;
  logic [RC_W-1:0] r_col;
  logic [DR_W-1:0] r_drain;
  logic            r_taps_done;   // tap walk finished, drain phase active

  assign tap_row    = r_row;
  assign tap_col    = r_col;
  assign last_tap   = ~r_taps_done & (r_row == c_last_rc) & (r_col == c_last_rc);
  assign drain_done = r_taps_done & (r_drain == c_last_drain);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row       <= '0;
      r_col       <= '0;
      r_drain     <= '0;
      r_taps_done <= 1'b0;
    end else if (start) begin
      r_row       <= '0;
      r_col       <= '0;
      r_drain     <= '0;
      r_taps_done <= 1'b0;
    end else if (en) begin
      if (!r_taps_done) begin
        // Coordinates freeze on the last tap; only the phase flag moves
        if (last_tap) begin
          r_taps_done <= 1'b1;
        end else if (r_col == c_last_rc) begin
          r_col <= '0;
          r_row <= r_row + RC_W'(1);
        end else begin
          r_col <= r_col + RC_W'(1);
        end
      end else if (!drain_done) begin
        r_drain <= r_drain + DR_W'(1);
      end
    end
  end

endmodule : conv_tap_counter
`default_nettype wire

// File: rtl/conv_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : conv_job_sequencer
// Purpose : Job-level controller for the shared-weight convolution PE grid.
//           Accepts one image+filter job, clears the PE accumulators, steps
//           the filter taps, waits for the PE pipeline, captures the sums and
//           presents them downstream under valid/ready.
// Ports   : clk, reset             - clock, async active-high reset
//           in_valid/in_ready      - job handshake, in_a image, in_b filter
//           abort                  - kill the in-flight job
//           pe_clear/pe_en         - PE accumulator clear / accumulate enable
//           tap_row/tap_col/b_tap  - current tap coordinate and weight
//           img                    - latched image, stable for the job
//           pe_sum                 - grid sums from the PE array
//           out_valid/out_ready    - result handshake, out_p captured result
//           busy                   - a job is in flight or awaiting handoff
//           job_count              - completed result handshakes (wraps)
// Revision: 1.0 - initial release
// ============================================================================
module conv_job_sequencer
  import conv_pkg::*;
#(
  parameter int N          = 3,
  parameter int M          = 2,
  parameter int data_width = 1,
  parameter int PIPE_LAT   = 1
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  in_valid,
  output logic                                                  in_ready,
  input  logic [N-1:0][N-1:0][data_width-1:0]                   in_a,
  input  logic [M-1:0][M-1:0][data_width-1:0]                   in_b,
  input  logic                                                  abort,
  output logic                                                  pe_clear,
  output logic                                                  pe_en,
  output logic [rc_w(M)-1:0]                                    tap_row,
  output logic [rc_w(M)-1:0]                                    tap_col,
  output logic [data_width-1:0]                                 b_tap,
  output logic [N-1:0][N-1:0][data_width-1:0]                   img,
  input  logic [out_size(N,M)-1:0][out_size(N,M)-1:0][2*data_width:0] pe_sum,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic [out_size(N,M)-1:0][out_size(N,M)-1:0][2*data_width:0] out_p,
  output logic                                                  busy,
  output logic [15:0]                                           job_count
);

  state_t r_state;
  state_t w_next;

  logic [M-1:0][M-1:0][data_width-1:0] r_b;
  logic [15:0]                         r_job_count;

  logic w_accept;
  logic w_out_hs;
  logic w_capture;
  logic w_cnt_start;
  logic w_cnt_en;
  logic w_last_tap;
  logic w_drain_done;

  // In OUT the slot frees on the result handshake, so a waiting job can be
  // taken in the same cycle without passing through IDLE.
  assign in_ready  = (r_state == IDLE) | ((r_state == OUT) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_out_hs  = out_valid & out_ready;
  assign w_capture = (r_state == DRAIN) & w_drain_done & ~abort;

  assign w_cnt_start = (r_state == CLEAR);
  assign w_cnt_en    = (r_state == RUN) | (r_state == DRAIN);

  assign b_tap     = r_b[tap_row][tap_col];
  assign job_count = r_job_count;

  conv_tap_counter #(
    .M        (M),
    .PIPE_LAT (PIPE_LAT)
  ) u_tap_counter (
    .clk        (clk),
    .reset      (reset),
    .start      (w_cnt_start),
    .en         (w_cnt_en),
    .tap_row    (tap_row),
    .tap_col    (tap_col),
    .last_tap   (w_last_tap),
    .drain_done (w_drain_done)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) w_next = CLEAR;
      end
      CLEAR: begin
        w_next = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort)           w_next = IDLE;
        else if (w_last_tap) w_next = DRAIN;
      end
      DRAIN: begin
        if (abort)             w_next = IDLE;
        else if (w_drain_done) w_next = OUT;
      end
      OUT: begin
        if (out_ready) w_next = in_valid ? CLEAR : IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Control outputs are registered from the next state so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pe_clear  <= 1'b0;
      pe_en     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pe_clear  <= (w_next == CLEAR);
      pe_en     <= (w_next == RUN);
      out_valid <= (w_next == OUT);
      busy      <= (w_next != IDLE);
    end
  end

  // Job latches: written only on accept, so input traffic while busy is ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      img <= '0;
      r_b <= '0;
    end else if (w_accept) begin
      img <= in_a;
      r_b <= in_b;
    end
  end

  // Result capture on the final drain cycle, suppressed by abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_p <= '0;
    end else if (w_capture) begin
      out_p <= pe_sum;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_job_count <= '0;
    end else if (w_out_hs) begin
      r_job_count <= r_job_count + 16'd1;
    end
  end

endmodule : conv_job_sequencer
`default_nettype wire

// File: tb/tb_conv_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_conv_job_sequencer
// Purpose : Self-checking bench for conv_job_sequencer with a behavioural
//           MAC grid (N=3, M=2, data_width=4, PIPE_LAT=1). Expected results
//           are queued when a job is issued and compared by a monitor at
//           each result handshake.
// Revision: 1.0 - initial release
// ============================================================================
module tb_conv_job_sequencer;

  localparam int N  = 3;
  localparam int M  = 2;
  localparam int DW = 4;
  localparam int PL = 1;
  localparam int OS = N - M + 1;
  localparam int SW = 2 * DW + 1;

  typedef logic [OS-1:0][OS-1:0][SW-1:0] res_t;

  logic                          clk = 1'b0;
  logic                          reset = 1'b1;
  logic                          in_valid;
  logic                          in_ready;
  logic [N-1:0][N-1:0][DW-1:0]   in_a;
  logic [M-1:0][M-1:0][DW-1:0]   in_b;
  logic                          abort;
  logic                          pe_clear;
  logic                          pe_en;
  logic [0:0]                    tap_row;
  logic [0:0]                    tap_col;
  logic [DW-1:0]                 b_tap;
  logic [N-1:0][N-1:0][DW-1:0]   img;
  res_t                          pe_sum;
  logic                          out_valid;
  logic                          out_ready;
  res_t                          out_p;
  logic                          busy;
  logic [15:0]                   job_count;

  res_t       acc = '0;
  res_t       sb_q[$];
  logic [1:0] taps_seen[$];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  conv_job_sequencer #(
    .N          (N),
    .M          (M),
    .data_width (DW),
    .PIPE_LAT   (PL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .abort     (abort),
    .pe_clear  (pe_clear),
    .pe_en     (pe_en),
    .tap_row   (tap_row),
    .tap_col   (tap_col),
    .b_tap     (b_tap),
    .img       (img),
    .pe_sum    (pe_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy),
    .job_count (job_count)
  );

  // Behavioural shared-weight MAC grid, one pipeline stage
  always @(posedge clk) begin
    if (pe_clear) begin
      acc <= '0;
    end else if (pe_en) begin
      for (int i = 0; i < OS; i++)
        for (int j = 0; j < OS; j++)
          acc[i][j] <= acc[i][j] + SW'(img[i + int'(tap_row)][j + int'(tap_col)]) * SW'(b_tap);
    end
  end
  assign pe_sum = acc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: one compare per result handshake
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got out_p=%0h with no job queued, expected none", out_p);
      end else begin
        res_t e;
        e = sb_q.pop_front();
        chk("out_p", 64'(out_p), 64'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t mk(input int e00, input int e01, input int e10, input int e11);
    res_t r;
    r[0][0] = SW'(e00);
    r[0][1] = SW'(e01);
    r[1][0] = SW'(e10);
    r[1][1] = SW'(e11);
    return r;
  endfunction

  task automatic set_a_seq();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        in_a[i][j] = DW'(i * N + j + 1);
  endtask

  task automatic set_b(input logic [DW-1:0] b00, input logic [DW-1:0] b01,
                       input logic [DW-1:0] b10, input logic [DW-1:0] b11);
    in_b[0][0] = b00;
    in_b[0][1] = b01;
    in_b[1][0] = b10;
    in_b[1][1] = b11;
  endtask

  task automatic offer(input res_t exp);
    in_valid = 1'b1;
    sb_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int lim, output int lat);
    lat = 0;
    taps_seen.delete();
    while (!out_valid && lat < lim) begin
      tick();
      lat++;
      if (pe_en) taps_seen.push_back({tap_row, tap_col});
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL out_valid_timeout: got out_valid=0 after %0d cycles, expected 1", lat);
    end
  endtask

  task automatic wait_tap(input logic r, input logic c);
    int w;
    w = 0;
    while (!(pe_en && tap_row == r && tap_col == c) && w < 20) begin
      tick();
      w++;
    end
    chk("reach_tap", 64'(pe_en && tap_row == r && tap_col == c), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int npe;
    int nov;
    in_valid = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    in_a = '0;
    in_b = '0;
    do_reset();

    // Reset state
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_pe_en",     64'(pe_en),     64'd0);
    chk("rst_pe_clear",  64'(pe_clear),  64'd0);
    chk("rst_job_count", 64'(job_count), 64'd0);
    chk("rst_out_p",     64'(out_p),     64'd0);
    chk("rst_img",       64'(img),       64'd0);

    // 1. Basic job, identity filter
    set_a_seq();
    set_b(1, 0, 0, 1);
    offer(mk(6, 8, 12, 14));
    chk("t1_pe_clear", 64'(pe_clear), 64'd1);
    chk("t1_in_ready", 64'(in_ready), 64'd0);
    wait_valid(30, lat);
    chk("t1_latency", 64'(lat), 64'd6);
    chk("t1_tap_count", 64'(taps_seen.size()), 64'd4);
    if (taps_seen.size() == 4)
      for (int k = 0; k < 4; k++) chk("t1_tap_order", 64'(taps_seen[k]), 64'(k));
    tick();
    chk("t1_job_count", 64'(job_count), 64'd1);
    chk("t1_idle", 64'({busy, in_ready, out_valid}), 64'b010);

    // 2. Back-to-back jobs
    do_reset();
    set_b(1, 0, 0, 1);
    in_valid = 1'b1;
    sb_q.push_back(mk(6, 8, 12, 14));
    tick();
    set_b(1, 1, 1, 1);
    sb_q.push_back(mk(12, 16, 24, 28));
    wait_valid(30, lat);
    chk("t2_in_ready_out", 64'(in_ready), 64'd1);
    tick();
    chk("t2_b2b_clear", 64'({pe_clear, busy}), 64'b11);
    in_valid = 1'b0;
    wait_valid(30, lat);
    chk("t2_latency", 64'(lat), 64'd6);
    tick();
    chk("t2_job_count", 64'(job_count), 64'd2);

    // 3. Backpressure, abort in OUT ignored
    out_ready = 1'b0;
    set_b(2, 0, 0, 0);
    offer(mk(2, 4, 8, 10));
    wait_valid(30, lat);
    npe = 0;
    for (int c = 0; c < 10; c++) begin
      abort = (c == 4);
      tick();
      if (pe_en) npe++;
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_out_p", 64'(out_p), 64'(mk(2, 4, 8, 10)));
    end
    abort = 1'b0;
    chk("t3_in_ready", 64'(in_ready), 64'd0);
    chk("t3_pe_en_pulses", 64'(npe), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("t3_job_count", 64'(job_count), 64'd3);

    // 4. Abort at RUN tap 2, then a clean job
    set_b(1, 1, 1, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_tap(1'b1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_abort_idle", 64'({busy, in_ready, pe_en}), 64'b010);
    nov = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) nov++;
    end
    chk("t4_no_out_valid", 64'(nov), 64'd0);
    chk("t4_job_count", 64'(job_count), 64'd3);
    chk("t4_out_p_kept", 64'(out_p), 64'(mk(2, 4, 8, 10)));
    set_b(0, 1, 0, 0);
    offer(mk(2, 3, 5, 6));
    wait_valid(30, lat);
    tick();
    chk("t4_job_count_after", 64'(job_count), 64'd4);

    // 5. Async reset mid-DRAIN, then recovery
    set_b(1, 1, 1, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_tap(1'b1, 1'b1);
    tick();
    chk("t5_in_drain", 64'({busy, pe_en}), 64'b10);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_ctrl", 64'({in_ready, busy, pe_en, pe_clear, out_valid}), 64'b10000);
    chk("t5_rst_taps", 64'({tap_row, tap_col}), 64'd0);
    chk("t5_rst_job_count", 64'(job_count), 64'd0);
    chk("t5_rst_out_p", 64'(out_p), 64'd0);
    chk("t5_rst_img", 64'(img), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    offer(mk(12, 16, 24, 28));
    wait_valid(30, lat);
    tick();
    chk("t5_job_count", 64'(job_count), 64'd1);

    // 6. job_count wrap
    force dut.r_job_count = 16'hFFFF;
    tick();
    release dut.r_job_count;
    tick();
    chk("t6_preload", 64'(job_count), 64'hFFFF);
    set_b(1, 0, 0, 1);
    offer(mk(6, 8, 12, 14));
    wait_valid(30, lat);
    tick();
    chk("t6_wrap", 64'(job_count), 64'd0);

    tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_conv_job_sequencer
`default_nettype wire
